neuron_mac: RTL and testbench
=============================

// Module: neuron_mac
// PURPOSE
//  Single-neuron compute engine for the MNIST network, driven directly by the
//  main layer controller (sn_rst / sn_start in, sn_ready out). Streams one
//  input/weight pair per cycle from the input shift register and weight
//  select path, accumulates x*w onto a bias, then applies shift, optional
//  ReLU and saturation. Its held result is loaded into the next layer's
//  register (ld1/ld2) or read as the final class score.
// PARAMETERS
//  DATA_W    8   signed input activation width
//  WEIGHT_W  8   signed weight width
//  ACC_W     24  signed accumulator width; must be >= DATA_W+WEIGHT_W+clog2(N_INPUTS)
//  N_INPUTS  62  products per neuron evaluation; >= 1
//  SHIFT     7   arithmetic right shift applied to acc before activation
//  OUT_W     8   signed output width
// PORTS
//  clk      in   1         clock, rising edge
//  rst      in   1         asynchronous, active-high reset
//  sn_rst   in   1         synchronous clear; returns block to IDLE
//  sn_start in   1         one-cycle start; first x/w pair valid in same cycle
//  x_in     in   DATA_W    signed input activation, one per cycle
//  w_in     in   WEIGHT_W  signed weight, one per cycle
//  bias     in   ACC_W     signed bias, sampled in the sn_start cycle
//  relu_en  in   1         1: clamp negative results to 0; sampled at FIN
//  sn_ready out  1         result valid; level, held until sn_rst/sn_start/rst
//  y_out    out  OUT_W     signed activated result, registered
// BEHAVIOUR
//  Reset (rst): state=IDLE, acc=0, cnt=0, sn_ready=0, y_out=0.
//  States: IDLE, ACC, FIN, DONE.
//  Priority per edge: rst > sn_rst > sn_start > state progression.
//  sn_rst (any state): acc=0, cnt=0, sn_ready=0, y_out=0, -> IDLE.
//  IDLE/DONE + sn_start: acc <= bias + x_in*w_in; cnt <= 1; sn_ready <= 0;
//    -> FIN if N_INPUTS==1, else -> ACC.
//  ACC: acc <= acc + x_in*w_in; cnt <= cnt+1; -> FIN when cnt==N_INPUTS-1
//    (i.e. after exactly N_INPUTS products total). sn_start ignored in ACC/FIN.
//  FIN: y_out <= act(acc); sn_ready <= 1; -> DONE. No product accumulated.
//  DONE: hold y_out and sn_ready=1 indefinitely.
//  Latency: start sampled at edge E0 -> sn_ready high after edge E(N_INPUTS).
//  Arithmetic: x*w full signed product (DATA_W+WEIGHT_W), sign-extended to
//    ACC_W; accumulation wraps at ACC_W (sizing rule prevents overflow).
//  act(a): s = a >>> SHIFT; if relu_en and s<0 -> 0;
//    else saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  x_in/w_in outside start/ACC cycles are don't-care.
// TESTING (bench uses N_INPUTS=4, SHIFT=0 unless noted)
//  1 start, x={1,2,3,4}, w={1,1,1,1}, bias=0 -> y_out=10, sn_ready rises
//    exactly 4 edges after start edge, held until sn_rst.
//  2 x={127}x4, w={127}x4, bias=0 -> acc=64516, y_out=127 (positive saturation).
//  3 x={-100}x4, w={100}x4, relu_en=0 -> y_out=-128; relu_en=1 -> y_out=0.
//  4 SHIFT=7, x={64}x4, w={64}x4, bias=128 -> (16384+128)>>>7 = 129 -> y_out=127;
//    bias=-16000 -> 384>>>7 = 3 -> y_out=3.
//  5 sn_rst asserted in 2nd ACC cycle -> IDLE, sn_ready=0, y_out=0; new start
//    then gives correct fresh result; sn_rst+sn_start same cycle -> IDLE.
//  6 rst asserted asynchronously mid-ACC and in DONE -> all outputs 0 at once;
//    sn_start during ACC ignored (result equals uninterrupted run).

Source files
------------

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate engine: bias + sum(x*w), then shift,
// optional ReLU and saturation into a held, registered result.
module neuron_mac #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 24,
    parameter int N_INPUTS = 62,
    parameter int SHIFT    = 7,
    parameter int OUT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sn_rst,
    input  logic                       sn_start,
    input  logic signed [DATA_W-1:0]   x_in,
    input  logic signed [WEIGHT_W-1:0] w_in,
    input  logic signed [ACC_W-1:0]    bias,
    input  logic                       relu_en,
    output logic                       sn_ready,
    output logic signed [OUT_W-1:0]    y_out
);

    localparam int P_W   = DATA_W + WEIGHT_W;
    localparam int CNT_W = $clog2(N_INPUTS + 1);

    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic signed [ACC_W-1:0]   acc_r, acc_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s;
    logic                      ready_r, ready_s;
    logic signed [OUT_W-1:0]   y_r, y_s;
    logic signed [P_W-1:0]     prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;

    // Shift, optional ReLU, then clamp to the signed output range.
    function automatic logic signed [OUT_W-1:0] act(input logic signed [ACC_W-1:0] a,
                                                    input logic relu);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (relu && s[ACC_W-1]) begin
            act = {OUT_W{1'b0}};
        end else if (s > Y_MAX) begin
            act = Y_MAX[OUT_W-1:0];
        end else if (s < Y_MIN) begin
            act = Y_MIN[OUT_W-1:0];
        end else begin
            act = s[OUT_W-1:0];
        end
    endfunction

    assign prod_s     = x_in * w_in;
    assign prod_ext_s = ACC_W'(prod_s);

    // Next-state and datapath update; sn_rst overrides everything, start only from IDLE/DONE.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        ready_s = ready_r;
        y_s     = y_r;
        if (sn_rst) begin
            state_s = IDLE;
            acc_s   = {ACC_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
            ready_s = 1'b0;
            y_s     = {OUT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (sn_start) begin
                        acc_s   = bias + prod_ext_s;
                        cnt_s   = CNT_W'(1);
                        ready_s = 1'b0;
                        state_s = (N_INPUTS == 1) ? FIN : ACC;
                    end else begin
                        state_s = state_r;
                    end
                end
                ACC: begin
                    acc_s = acc_r + prod_ext_s;
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(N_INPUTS - 1)) begin
                        state_s = FIN;
                    end else begin
                        state_s = ACC;
                    end
                end
                FIN: begin
                    y_s     = act(acc_r, relu_en);
                    ready_s = 1'b1;
                    state_s = DONE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
            y_r     <= {OUT_W{1'b0}};
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            ready_r <= ready_s;
            y_r     <= y_s;
        end
    end

    assign sn_ready = ready_r;
    assign y_out    = y_r;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: two instances (shift 0 and shift 7, four inputs) share
// stimulus and are checked against an arithmetic reference of the neuron.
module tb_neuron_mac;

    logic clk = 1'b0;
    logic rst, sn_rst, sn_start, relu_en;
    logic signed [7:0]  x_in, w_in;
    logic signed [23:0] bias;
    logic               r0, r7;
    logic signed [7:0]  y0, y7;
    int n_tests = 0;
    int n_fail  = 0;
    logic signed [7:0] xv[4];
    logic signed [7:0] wv[4];

    always #5 clk = ~clk;

    neuron_mac #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .N_INPUTS(4), .SHIFT(0), .OUT_W(8)) d0 (
        .clk(clk), .rst(rst), .sn_rst(sn_rst), .sn_start(sn_start), .x_in(x_in), .w_in(w_in),
        .bias(bias), .relu_en(relu_en), .sn_ready(r0), .y_out(y0));

    neuron_mac #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .N_INPUTS(4), .SHIFT(7), .OUT_W(8)) d7 (
        .clk(clk), .rst(rst), .sn_rst(sn_rst), .sn_start(sn_start), .x_in(x_in), .w_in(w_in),
        .bias(bias), .relu_en(relu_en), .sn_ready(r7), .y_out(y7));

    // Neuron output from the arithmetic definition: bias plus dot product, shift, relu, clamp.
    function automatic int model(input int sh, input int b, input logic relu);
        longint acc;
        longint s;
        acc = longint'(b);
        for (int i = 0; i < 4; i++) acc += longint'(xv[i]) * longint'(wv[i]);
        s = acc >>> sh;
        if (relu && s < 0) return 0;
        if (s > 127) return 127;
        if (s < -128) return -128;
        return int'(s);
    endfunction

    // Full evaluation; ends at the negedge after the result edge. inject pulses start during ACC/FIN.
    task automatic run_neuron(input int b, input logic relu, input bit inject);
        @(negedge clk);
        sn_start = 1'b1; bias = 24'(b); relu_en = relu; x_in = xv[0]; w_in = wv[0];
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            sn_start = inject && (i >= 2);
            x_in = xv[i]; w_in = wv[i];
        end
        @(negedge clk);
        sn_start = inject;
        x_in = 8'($urandom); w_in = 8'($urandom);
        @(negedge clk);
        sn_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sn_rst = 1'b0; sn_start = 1'b0; relu_en = 1'b0;
        x_in = 8'sd0; w_in = 8'sd0; bias = 24'sd0;
        repeat (2) @(negedge clk);
        n_tests++; if ({r0, r7} !== 2'b00 || y0 !== 8'sd0 || y7 !== 8'sd0) begin
            n_fail++; $display("FAIL reset_state got r=%b%b y=%0d/%0d exp r=00 y=0/0", r0, r7, y0, y7);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (r0 !== 1'b0 || y0 !== 8'sd0) begin
            n_fail++; $display("FAIL idle_after_reset got r=%b y=%0d exp r=0 y=0", r0, y0);
        end
    endtask

    task automatic test_sum();
        xv = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        wv = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        @(negedge clk);
        sn_start = 1'b1; bias = 24'sd0; relu_en = 1'b0; x_in = xv[0]; w_in = wv[0];
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_tests++; if (r0 !== 1'b0) begin
                n_fail++; $display("FAIL latency_early edge %0d got ready=%b exp 0", i - 1, r0);
            end
            sn_start = 1'b0;
            if (i < 4) begin
                x_in = xv[i]; w_in = wv[i];
            end else begin
                x_in = 8'($urandom); w_in = 8'($urandom);
            end
        end
        @(negedge clk);
        n_tests++; if (r0 !== 1'b1 || y0 !== 8'sd10) begin
            n_fail++; $display("FAIL sum_result got r=%b y=%0d exp r=1 y=10", r0, y0);
        end
        n_tests++; if (r7 !== 1'b1 || int'(y7) !== model(7, 0, 1'b0)) begin
            n_fail++; $display("FAIL sum_result_sh7 got r=%b y=%0d exp r=1 y=%0d", r7, y7, model(7, 0, 1'b0));
        end
        repeat (5) @(negedge clk);
        n_tests++; if (r0 !== 1'b1 || y0 !== 8'sd10) begin
            n_fail++; $display("FAIL sum_hold got r=%b y=%0d exp r=1 y=10", r0, y0);
        end
        sn_rst = 1'b1;
        @(negedge clk);
        sn_rst = 1'b0;
        n_tests++; if (r0 !== 1'b0 || y0 !== 8'sd0) begin
            n_fail++; $display("FAIL sum_sn_rst_clear got r=%b y=%0d exp r=0 y=0", r0, y0);
        end
    endtask

    task automatic test_saturation();
        xv = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        wv = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        run_neuron(0, 1'b0, 1'b0);
        n_tests++; if (y0 !== 8'sd127 || y7 !== 8'sd127) begin
            n_fail++; $display("FAIL pos_saturation got y=%0d/%0d exp 127/127", y0, y7);
        end
        xv = '{-8'sd100, -8'sd100, -8'sd100, -8'sd100};
        wv = '{8'sd100, 8'sd100, 8'sd100, 8'sd100};
        run_neuron(0, 1'b0, 1'b0);
        n_tests++; if (y0 !== -8'sd128 || int'(y7) !== model(7, 0, 1'b0)) begin
            n_fail++; $display("FAIL neg_saturation got y=%0d/%0d exp -128/%0d", y0, y7, model(7, 0, 1'b0));
        end
        run_neuron(0, 1'b1, 1'b0);
        n_tests++; if (y0 !== 8'sd0 || y7 !== 8'sd0) begin
            n_fail++; $display("FAIL relu_clamp got y=%0d/%0d exp 0/0", y0, y7);
        end
    endtask

    task automatic test_shift();
        xv = '{8'sd64, 8'sd64, 8'sd64, 8'sd64};
        wv = '{8'sd64, 8'sd64, 8'sd64, 8'sd64};
        run_neuron(128, 1'b0, 1'b0);
        n_tests++; if (y7 !== 8'sd127 || y0 !== 8'sd127) begin
            n_fail++; $display("FAIL shift_saturate got y7=%0d y0=%0d exp 127/127", y7, y0);
        end
        run_neuron(-16000, 1'b0, 1'b0);
        n_tests++; if (y7 !== 8'sd3 || y0 !== 8'sd127) begin
            n_fail++; $display("FAIL shift_small got y7=%0d y0=%0d exp 3/127", y7, y0);
        end
    endtask

    task automatic test_sn_rst_mid();
        int e0;
        xv = '{8'sd5, 8'sd5, 8'sd5, 8'sd5};
        wv = '{8'sd5, 8'sd5, 8'sd5, 8'sd5};
        run_neuron(0, 1'b0, 1'b0);
        @(negedge clk);
        sn_start = 1'b1; bias = 24'sd0; x_in = xv[0]; w_in = wv[0];
        @(negedge clk);
        sn_start = 1'b0; x_in = xv[1]; w_in = wv[1];
        @(negedge clk);
        sn_rst = 1'b1;
        @(negedge clk);
        sn_rst = 1'b0;
        n_tests++; if (r0 !== 1'b0 || y0 !== 8'sd0) begin
            n_fail++; $display("FAIL sn_rst_mid got r=%b y=%0d exp r=0 y=0", r0, y0);
        end
        repeat (5) @(negedge clk);
        n_tests++; if (r0 !== 1'b0 || r7 !== 1'b0) begin
            n_fail++; $display("FAIL sn_rst_stays_idle got r=%b%b exp 00", r0, r7);
        end
        for (int i = 0; i < 4; i++) begin
            xv[i] = 8'($urandom); wv[i] = 8'($urandom);
        end
        e0 = int'($urandom_range(0, 2000)) - 1000;
        run_neuron(e0, 1'b0, 1'b0);
        n_tests++; if (r0 !== 1'b1 || int'(y0) !== model(0, e0, 1'b0) || int'(y7) !== model(7, e0, 1'b0)) begin
            n_fail++; $display("FAIL fresh_after_sn_rst got r=%b y=%0d/%0d exp r=1 y=%0d/%0d",
                               r0, y0, y7, model(0, e0, 1'b0), model(7, e0, 1'b0));
        end
        @(negedge clk);
        sn_rst = 1'b1; sn_start = 1'b1;
        @(negedge clk);
        sn_rst = 1'b0; sn_start = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++; if (r0 !== 1'b0 || y0 !== 8'sd0) begin
            n_fail++; $display("FAIL sn_rst_beats_start got r=%b y=%0d exp r=0 y=0", r0, y0);
        end
    endtask

    task automatic test_async_rst();
        xv = '{8'sd5, 8'sd5, 8'sd5, 8'sd5};
        wv = '{8'sd5, 8'sd5, 8'sd5, 8'sd5};
        run_neuron(0, 1'b0, 1'b0);
        @(negedge clk);
        sn_start = 1'b1; bias = 24'sd0; x_in = xv[0]; w_in = wv[0];
        @(negedge clk);
        sn_start = 1'b0; x_in = xv[1]; w_in = wv[1];
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({r0, r7} !== 2'b00 || y0 !== 8'sd0 || y7 !== 8'sd0) begin
            n_fail++; $display("FAIL async_rst_acc got r=%b%b y=%0d/%0d exp 00 0/0", r0, r7, y0, y7);
        end
        @(negedge clk);
        rst = 1'b0;
        run_neuron(0, 1'b0, 1'b0);
        n_tests++; if (r0 !== 1'b1 || y0 !== 8'sd100) begin
            n_fail++; $display("FAIL run_before_rst got r=%b y=%0d exp r=1 y=100", r0, y0);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({r0, r7} !== 2'b00 || y0 !== 8'sd0 || y7 !== 8'sd0) begin
            n_fail++; $display("FAIL async_rst_done got r=%b%b y=%0d/%0d exp 00 0/0", r0, r7, y0, y7);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int  b;
        logic relu;
        bit  inj;
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 4; i++) begin
                xv[i] = 8'($urandom); wv[i] = 8'($urandom);
            end
            b    = int'($urandom_range(0, 2097152)) - 1048576;
            relu = 1'($urandom);
            inj  = 1'($urandom);
            run_neuron(b, relu, inj);
            n_tests++; if (r0 !== 1'b1 || int'(y0) !== model(0, b, relu)) begin
                n_fail++; $display("FAIL random_sh0 #%0d got r=%b y=%0d exp r=1 y=%0d", t, r0, y0, model(0, b, relu));
            end
            n_tests++; if (r7 !== 1'b1 || int'(y7) !== model(7, b, relu)) begin
                n_fail++; $display("FAIL random_sh7 #%0d got r=%b y=%0d exp r=1 y=%0d", t, r7, y7, model(7, b, relu));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_saturation();
        test_shift();
        test_sn_rst_mid();
        test_async_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
